// File: rtl/geet_fifo_prog_thresh_if.sv
// Handshake and status bundle for the programmable-threshold FIFO.
// The master side drives requests and thresholds; the slave side is the FIFO itself.
interface geet_fifo_prog_thresh_if #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int LOG2_FIFO_DEPTH = 6
);
  localparam int CW = LOG2_FIFO_DEPTH + 1;

  logic                       wr_en;
  logic [FIFO_DATA_WIDTH-1:0] d_in;
  logic                       rd_en;
  logic [FIFO_DATA_WIDTH-1:0] d_out;
  logic                       d_valid;
  logic [CW-1:0]              af_thresh;
  logic [CW-1:0]              ae_thresh;
  logic [CW-1:0]              count;
  logic                       empty;
  logic                       full;
  logic                       almost_full;
  logic                       almost_empty;
  logic                       overflow;
  logic                       underflow;
  logic                       clr_err;

  modport master (
    output wr_en, d_in, rd_en, af_thresh, ae_thresh, clr_err,
    input  d_out, d_valid, count, empty, full, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  wr_en, d_in, rd_en, af_thresh, ae_thresh, clr_err,
    output d_out, d_valid, count, empty, full, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/geet_fifo_prog_thresh.sv
// Synchronous FIFO with registered occupancy, programmable almost-full/empty
// thresholds, one-cycle registered read data and sticky overflow/underflow flags.
module geet_fifo_prog_thresh #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int LOG2_FIFO_DEPTH = 6
) (
  input logic                    clk,
  input logic                    reset_n,
  geet_fifo_prog_thresh_if.slave fifo_if
);
  localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
  localparam int CW    = LOG2_FIFO_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

  logic [FIFO_DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]              wr_ptr;
  logic [CW-1:0]              rd_ptr;
  logic [CW-1:0]              next_count;
  logic                       wa;
  logic                       ra;

  // Acceptance uses the registered flags only, so a full FIFO never bypasses
  // a simultaneous read into a write.
  always_comb begin
    wa         = fifo_if.wr_en && !fifo_if.full;
    ra         = fifo_if.rd_en && !fifo_if.empty;
    next_count = fifo_if.count + CW'(wa) - CW'(ra);
  end

  always_ff @(posedge clk) begin
    if (wa) begin
      mem[wr_ptr[LOG2_FIFO_DEPTH-1:0]] <= fifo_if.d_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + 1'b1;
      if (ra) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_if.d_out   <= '0;
      fifo_if.d_valid <= 1'b0;
    end else begin
      fifo_if.d_valid <= ra;
      if (ra) begin
        fifo_if.d_out <= mem[rd_ptr[LOG2_FIFO_DEPTH-1:0]];
      end
    end
  end

  // Status is registered from the post-update occupancy so it is exact
  // in the same cycle count changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_if.count        <= '0;
      fifo_if.empty        <= 1'b1;
      fifo_if.full         <= 1'b0;
      fifo_if.almost_full  <= 1'b0;
      fifo_if.almost_empty <= 1'b1;
    end else begin
      fifo_if.count        <= next_count;
      fifo_if.empty        <= (next_count == '0);
      fifo_if.full         <= (next_count == DEPTH_CW);
      fifo_if.almost_full  <= (next_count >= fifo_if.af_thresh);
      fifo_if.almost_empty <= (next_count <= fifo_if.ae_thresh);
    end
  end

  // A new error outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_if.overflow  <= 1'b0;
      fifo_if.underflow <= 1'b0;
    end else begin
      if (fifo_if.wr_en && fifo_if.full)       fifo_if.overflow <= 1'b1;
      else if (fifo_if.clr_err)                fifo_if.overflow <= 1'b0;
      if (fifo_if.rd_en && fifo_if.empty)      fifo_if.underflow <= 1'b1;
      else if (fifo_if.clr_err)                fifo_if.underflow <= 1'b0;
    end
  end
endmodule

// File: doc/geet_fifo_prog_thresh.md
GEET_FIFO_PROG_THRESH -- requirements
Module: geet_fifo_prog_thresh

Interface
REQ-001 Parameter FIFO_DATA_WIDTH, default 32, SHALL set the data width in bits.
REQ-002 Parameter LOG2_FIFO_DEPTH, default 6, SHALL set the depth as DEPTH = 2^LOG2_FIFO_DEPTH (legal range 1..12); CW = LOG2_FIFO_DEPTH+1.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 wr_en  input  1  write request; d_in  input  FIFO_DATA_WIDTH  write data.
REQ-006 rd_en  input  1  read request; d_out  output  FIFO_DATA_WIDTH  registered read data; d_valid  output  1  d_out carries a newly read word.
REQ-007 af_thresh  input  CW  almost-full threshold; ae_thresh  input  CW  almost-empty threshold; both quasi-static.
REQ-008 count  output  CW  registered occupancy, 0..DEPTH.
REQ-009 empty, full, almost_full, almost_empty  output  1 each  registered status flags.
REQ-010 overflow, underflow  output  1 each  sticky error flags; clr_err  input  1  synchronous clear of both.

Function
REQ-011 Write accepted (wa) SHALL be wr_en && !full; read accepted (ra) SHALL be rd_en && !empty; flags sampled are the current registered values.
REQ-012 Pointers SHALL be CW bits wide, increment by 1 on wa / ra respectively, and wrap modulo 2*DEPTH; memory index = low LOG2_FIFO_DEPTH bits.
REQ-013 On wa, d_in SHALL be written to mem[wr_ptr]; memory array SHALL NOT be reset.
REQ-014 On ra, d_out SHALL load mem[rd_ptr] at that edge and d_valid SHALL be 1 for exactly the following cycle (read latency 1).
REQ-015 Without ra, d_out SHALL hold its value and d_valid SHALL be 0.
REQ-016 next_count SHALL be count + wa - ra; count SHALL load next_count each edge.
REQ-017 Flags SHALL be registered from next_count: empty = (next_count==0), full = (next_count==DEPTH), almost_full = (next_count >= af_thresh), almost_empty = (next_count <= ae_thresh).
REQ-018 A word written at edge N SHALL be readable by rd_en at edge N+1 (empty deasserted after edge N).
REQ-019 Simultaneous wa and ra SHALL leave count unchanged; data ordering SHALL be preserved.
REQ-020 wr_en while full and rd_en asserted: read accepted, write rejected, overflow set (no bypass).
REQ-021 rd_en while empty and wr_en asserted: write accepted, read rejected, underflow set.
REQ-022 overflow SHALL set on wr_en && full; underflow SHALL set on rd_en && empty; both hold until clr_err or reset.
REQ-023 clr_err and a new error in the same cycle: set SHALL win.
REQ-024 af_thresh > DEPTH SHALL keep almost_full 0; ae_thresh >= DEPTH SHALL keep almost_empty 1 once clocked.
REQ-025 Rejected requests SHALL NOT change pointers, count, memory or d_out.

Reset
REQ-026 reset_n low SHALL immediately force pointers=0, count=0, empty=1, full=0, almost_full=0, almost_empty=1, d_out=0, d_valid=0, overflow=0, underflow=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored words; first edge after release behaves as an empty FIFO.
REQ-028 Reset release SHALL be synchronised by the instantiating level; the block assumes release is clean w.r.t. clk.

Verification (LOG2_FIFO_DEPTH=2, DEPTH=4, af_thresh=3, ae_thresh=1)
REQ-029 Write 0xA,0xB,0xC,0xD on consecutive cycles -> count 1,2,3,4; almost_full after 3rd write; full after 4th; almost_empty drops after 2nd write.
REQ-030 From full, 4 consecutive reads -> d_out 0xA,0xB,0xC,0xD each with d_valid one cycle after rd_en; empty after 4th read.
REQ-031 Full, wr_en+rd_en same cycle -> count 3, overflow=1, d_out=oldest word; clr_err next cycle -> overflow=0.
REQ-032 Empty, rd_en+wr_en(0x5) same cycle -> count 1, underflow=1, d_valid=0; read next cycle -> d_out=0x5.
REQ-033 Continuous simultaneous wr/rd for 20 cycles at count 2 -> count stays 2, pointers wrap past 7->0, output order matches input.
REQ-034 reset_n pulsed low asynchronously at count 3 -> all outputs at reset values before next clk edge; subsequent read gives underflow.
